// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-granular round-robin arbiter sharing one UART TX byte engine
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16,
  parameter int HOLD_TMO  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_data_i,
  input  logic [NREQ-1:0]   req_last_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic              tx_valid_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_done_i,
  output logic [NREQ-1:0]   grant_o,
  output logic              busy_o
);

  localparam int IW = $clog2(NREQ);
  localparam logic [IW:0]   NREQ_W    = NREQ[IW:0];
  localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);
  localparam logic [7:0]    BURST_MAX = 8'(MAX_BURST);
  localparam logic [15:0]   TMO_LAST  = 16'(HOLD_TMO - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, HOLD} state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   gidx_q;
  logic [NREQ-1:0] grant_q;
  logic [7:0]      data_q;
  logic [7:0]      burst_q;
  logic [15:0]     tmo_q;
  logic            last_q;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [IW:0]     scan_j;
  logic [7:0]      pick_data;
  logic [7:0]      own_data;
  logic            own_valid;
  logic [IW-1:0]   next_ptr;

  // Scan ptr, ptr+1, ... wrapping at NREQ so non-power-of-two counts work.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_j = {1'b0, ptr_q} + k[IW:0];
      if (scan_j >= NREQ_W) scan_j = scan_j - NREQ_W;
      if (!pick_found && req_valid_i[scan_j[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_j[IW-1:0];
      end
    end
  end

  assign pick_data = req_data_i[{pick_idx, 3'b000} +: 8];
  assign own_data  = req_data_i[{gidx_q, 3'b000} +: 8];
  assign own_valid = req_valid_i[gidx_q];
  assign next_ptr  = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      data_q  <= 8'h00;
      burst_q <= 8'h00;
      tmo_q   <= 16'h0000;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            gidx_q  <= pick_idx;
            grant_q <= NREQ'(1) << pick_idx;
            data_q  <= pick_data;
            burst_q <= 8'h00;
            state_q <= SEND;
          end
        end
        SEND: begin
          last_q  <= req_last_i[gidx_q];
          burst_q <= burst_q + 8'd1;
          state_q <= WAIT;
        end
        WAIT: begin
          if (tx_done_i) begin
            if (last_q || (burst_q == BURST_MAX)) begin
              grant_q <= '0;
              ptr_q   <= next_ptr;
              state_q <= IDLE;
            end else if (own_valid) begin
              data_q  <= own_data;
              state_q <= SEND;
            end else begin
              tmo_q   <= 16'h0000;
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (own_valid) begin
            data_q  <= own_data;
            state_q <= SEND;
          end else if (tmo_q == TMO_LAST) begin
            grant_q <= '0;
            ptr_q   <= next_ptr;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_valid_o  = (state_q == SEND);
  assign req_ready_o = tx_valid_o ? grant_q : '0;
  assign busy_o      = (state_q != IDLE);
  assign grant_o     = grant_q;
  assign tx_data_o   = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed scenario bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int MAX_BURST = 16;
  localparam int HOLD_TMO = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid_i;
  logic [8*NREQ-1:0] req_data_i;
  logic [NREQ-1:0]   req_last_i;
  logic [NREQ-1:0]   req_ready_o;
  logic              tx_valid_o;
  logic [7:0]        tx_data_o;
  logic              tx_done_i;
  logic [NREQ-1:0]   grant_o;
  logic              busy_o;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST), .HOLD_TMO(HOLD_TMO)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_last_i(req_last_i), .req_ready_o(req_ready_o), .tx_valid_o(tx_valid_o),
    .tx_data_o(tx_data_o), .tx_done_i(tx_done_i), .grant_o(grant_o), .busy_o(busy_o)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] qd [NREQ][32];
  logic       ql [NREQ][32];
  int         qg [NREQ][32];
  int         qn [NREQ];
  int         qi [NREQ];
  int         avail [NREQ];
  logic       adv [NREQ];
  int         rdy_cnt [NREQ];
  int cyc, tx_lat, done_at, ev_n, dn_n, oh_bad, busy_cnt;
  logic [3:0] ev_g [64];
  logic [7:0] ev_d [64];
  int         ev_c [64];
  int         dn_c [64];
  logic [3:0] gr_log [1024];

  task automatic clear_model();
    for (int i = 0; i < NREQ; i++) begin
      qn[i] = 0; qi[i] = 0; avail[i] = 0; adv[i] = 1'b0; rdy_cnt[i] = 0;
    end
    cyc = 0; done_at = -1; ev_n = 0; dn_n = 0; oh_bad = 0; busy_cnt = 0; tx_lat = 2;
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic last, input int gap);
    if (qn[i] == 0) avail[i] = cyc + gap;
    qd[i][qn[i]] = d; ql[i][qn[i]] = last; qg[i][qn[i]] = gap;
    qn[i]++;
  endtask

  task automatic drive_req();
    for (int i = 0; i < NREQ; i++) begin
      if (qi[i] < qn[i] && cyc >= avail[i]) begin
        req_valid_i[i] = 1'b1; req_data_i[8*i +: 8] = qd[i][qi[i]]; req_last_i[i] = ql[i][qi[i]];
      end else begin
        req_valid_i[i] = 1'b0; req_data_i[8*i +: 8] = 8'h00; req_last_i[i] = 1'b0;
      end
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1; req_valid_i = '0; req_data_i = '0; req_last_i = '0; tx_done_i = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  // Requesters advance one cycle after their ready pulse; TX engine answers tx_lat cycles after a start.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NREQ; i++) begin
        if (adv[i]) begin
          qi[i]++; adv[i] = 1'b0;
          avail[i] = cyc + ((qi[i] < qn[i]) ? qg[i][qi[i]] : 0);
        end
      end
      drive_req();
      tx_done_i = (cyc == done_at);
      if (tx_done_i && dn_n < 64) begin dn_c[dn_n] = cyc; dn_n++; end
      if (cyc < 1024) gr_log[cyc] = grant_o;
      if (busy_o) busy_cnt++;
      if ($countones(grant_o) > 1 || $countones(req_ready_o) > 1 || (req_ready_o & ~grant_o) != '0)
        oh_bad++;
      if (tx_valid_o) begin
        if (ev_n < 64) begin ev_g[ev_n] = grant_o; ev_d[ev_n] = tx_data_o; ev_c[ev_n] = cyc; ev_n++; end
        done_at = cyc + tx_lat;
      end
      for (int i = 0; i < NREQ; i++) if (req_ready_o[i]) begin adv[i] = 1'b1; rdy_cnt[i]++; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid_i = '1; req_data_i = '1; req_last_i = '0; tx_done_i = 1'b1;
    @(negedge clk); @(negedge clk);
    vectors++; if (grant_o !== 4'b0000) begin miscompares++; $display("FAIL reset_grant got %b exp 0000", grant_o); end
    vectors++; if (req_ready_o !== 4'b0000) begin miscompares++; $display("FAIL reset_ready got %b exp 0000", req_ready_o); end
    vectors++; if (tx_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_txvalid got %b exp 0", tx_valid_o); end
    vectors++; if (tx_data_o !== 8'h00) begin miscompares++; $display("FAIL reset_txdata got %h exp 00", tx_data_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy_o); end
  endtask

  task automatic test_single_msg();
    int bad;
    reset_dut();
    push(0, 8'h41, 1'b0, 0); push(0, 8'h42, 1'b0, 0); push(0, 8'h43, 1'b1, 0);
    run(20);
    vectors++; if (ev_n !== 3) begin miscompares++; $display("FAIL single_count got %0d exp 3", ev_n); end
    vectors++; if (ev_c[0] !== 2) begin miscompares++; $display("FAIL single_latency got %0d exp 2", ev_c[0]); end
    for (int k = 0; k < 3; k++) begin
      vectors++; if (ev_d[k] !== 8'h41 + k[7:0]) begin miscompares++; $display("FAIL single_data%0d got %h exp %h", k, ev_d[k], 8'h41 + k[7:0]); end
    end
    bad = 0;
    for (int c = ev_c[0]; c <= dn_c[2] && c < 1024; c++) if (gr_log[c] !== 4'b0001) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL single_grant_hold got %0d bad cycles exp 0", bad); end
    vectors++; if (gr_log[dn_c[2] + 1] !== 4'b0000) begin miscompares++; $display("FAIL single_release got %b exp 0000", gr_log[dn_c[2] + 1]); end
    vectors++; if (rdy_cnt[0] !== 3) begin miscompares++; $display("FAIL single_ready_cnt got %0d exp 3", rdy_cnt[0]); end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg [5];
    logic [7:0] ed [5];
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ed = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hA1};
    reset_dut();
    push(0, 8'hA0, 1'b1, 0); push(0, 8'hA1, 1'b1, 0);
    push(1, 8'hB0, 1'b1, 0); push(2, 8'hC0, 1'b1, 0); push(3, 8'hD0, 1'b1, 0);
    run(40);
    vectors++; if (ev_n !== 5) begin miscompares++; $display("FAIL rr_count got %0d exp 5", ev_n); end
    for (int k = 0; k < 5; k++) begin
      vectors++; if (ev_g[k] !== eg[k] || ev_d[k] !== ed[k]) begin
        miscompares++; $display("FAIL rr_order%0d got %b/%h exp %b/%h", k, ev_g[k], ev_d[k], eg[k], ed[k]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      vectors++; if (ev_c[k+1] - dn_c[k] !== 2) begin miscompares++; $display("FAIL rr_gap%0d got %0d exp 2", k, ev_c[k+1] - dn_c[k]); end
    end
    vectors++; if (oh_bad !== 0) begin miscompares++; $display("FAIL rr_onehot got %0d exp 0", oh_bad); end
  endtask

  task automatic test_max_burst();
    int bad;
    reset_dut();
    for (int k = 0; k < 20; k++) push(1, 8'h10 + k[7:0], 1'b0, 0);
    push(2, 8'hEE, 1'b1, 0);
    run(200);
    vectors++; if (ev_n !== 21) begin miscompares++; $display("FAIL burst_count got %0d exp 21", ev_n); end
    bad = 0;
    for (int k = 0; k < 16; k++) if (ev_g[k] !== 4'b0010) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL burst_first16 got %0d bad exp 0", bad); end
    vectors++; if (ev_g[16] !== 4'b0100 || ev_d[16] !== 8'hEE) begin miscompares++; $display("FAIL burst_rotate got %b/%h exp 0100/ee", ev_g[16], ev_d[16]); end
    vectors++; if (ev_c[16] - dn_c[15] !== 2) begin miscompares++; $display("FAIL burst_gap got %0d exp 2", ev_c[16] - dn_c[15]); end
    vectors++; if (ev_g[17] !== 4'b0010 || ev_d[17] !== 8'h20) begin miscompares++; $display("FAIL burst_resume got %b/%h exp 0010/20", ev_g[17], ev_d[17]); end
    vectors++; if (grant_o !== 4'b0000) begin miscompares++; $display("FAIL burst_final_idle got %b exp 0000", grant_o); end
  endtask

  task automatic test_hold_timeout();
    int bad;
    reset_dut();
    push(0, 8'h55, 1'b0, 0); push(0, 8'h56, 1'b1, 500);
    run(80);
    vectors++; if (ev_n !== 1) begin miscompares++; $display("FAIL hold_count got %0d exp 1", ev_n); end
    vectors++; if (gr_log[dn_c[0] + HOLD_TMO] !== 4'b0001) begin miscompares++; $display("FAIL hold_last_owned got %b exp 0001", gr_log[dn_c[0] + HOLD_TMO]); end
    vectors++; if (gr_log[dn_c[0] + HOLD_TMO + 1] !== 4'b0000) begin miscompares++; $display("FAIL hold_release got %b exp 0000", gr_log[dn_c[0] + HOLD_TMO + 1]); end
    reset_dut();
    push(0, 8'h55, 1'b0, 0); push(0, 8'h56, 1'b1, 12);
    run(40);
    vectors++; if (ev_n !== 2 || ev_d[1] !== 8'h56) begin miscompares++; $display("FAIL hold_resume got %0d/%h exp 2/56", ev_n, ev_d[1]); end
    vectors++; if (ev_c[1] - ev_c[0] !== 14) begin miscompares++; $display("FAIL hold_resume_time got %0d exp 14", ev_c[1] - ev_c[0]); end
    bad = 0;
    for (int c = ev_c[0]; c <= ev_c[1] && c < 1024; c++) if (gr_log[c] !== 4'b0001) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL hold_no_release got %0d bad exp 0", bad); end
  endtask

  task automatic test_spurious_and_reset();
    int guard;
    reset_dut();
    done_at = 3;
    run(6);
    vectors++; if (busy_cnt !== 0 || ev_n !== 0) begin miscompares++; $display("FAIL idle_spurious got busy %0d tx %0d exp 0/0", busy_cnt, ev_n); end
    reset_dut();
    push(0, 8'h77, 1'b0, 0); push(0, 8'h78, 1'b1, 500);
    run(8);
    done_at = cyc + 1;
    run(3);
    vectors++; if (busy_o !== 1'b1 || grant_o !== 4'b0001 || tx_valid_o !== 1'b0 || ev_n !== 1) begin
      miscompares++; $display("FAIL hold_spurious got busy %b grant %b txv %b tx %0d exp 1/0001/0/1", busy_o, grant_o, tx_valid_o, ev_n);
    end
    run(70);
    push(1, 8'h99, 1'b0, 0);
    tx_lat = 100;
    guard = 0;
    while (ev_n < 2 && guard < 10) begin run(1); guard++; end
    vectors++; if (ev_n !== 2 || ev_g[1] !== 4'b0010) begin miscompares++; $display("FAIL ptr_advance got %0d/%b exp 2/0010", ev_n, ev_g[1]); end
    run(1);
    vectors++; if (busy_o !== 1'b1 || tx_valid_o !== 1'b0) begin miscompares++; $display("FAIL in_wait got busy %b txv %b exp 1/0", busy_o, tx_valid_o); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (grant_o !== 4'b0000 || busy_o !== 1'b0 || tx_valid_o !== 1'b0 || tx_data_o !== 8'h00 || req_ready_o !== 4'b0000) begin
      miscompares++; $display("FAIL wait_reset got g %b b %b v %b d %h r %b exp 0000/0/0/00/0000", grant_o, busy_o, tx_valid_o, tx_data_o, req_ready_o);
    end
    rst = 1'b0;
    clear_model();
    push(0, 8'hA5, 1'b1, 0); push(2, 8'hC5, 1'b1, 0);
    run(10);
    vectors++; if (ev_n < 1 || ev_g[0] !== 4'b0001) begin miscompares++; $display("FAIL reset_ptr got %b exp 0001", ev_g[0]); end
  endtask

  task automatic test_back_to_back();
    int bad;
    reset_dut();
    tx_lat = 3;
    push(0, 8'h61, 1'b0, 0); push(0, 8'h62, 1'b1, 2);
    run(20);
    vectors++; if (ev_n !== 2 || ev_d[1] !== 8'h62) begin miscompares++; $display("FAIL b2b_count got %0d/%h exp 2/62", ev_n, ev_d[1]); end
    vectors++; if (ev_c[1] - dn_c[0] !== 1) begin miscompares++; $display("FAIL b2b_gap got %0d exp 1", ev_c[1] - dn_c[0]); end
    bad = 0;
    for (int c = ev_c[0]; c <= ev_c[1] && c < 1024; c++) if (gr_log[c] !== 4'b0001) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL b2b_no_idle got %0d bad exp 0", bad); end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_single_msg();
    test_round_robin();
    test_max_burst();
    test_hold_timeout();
    test_spurious_and_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
